// File: rtl/mem_bus_arbiter.sv
// Three-master / three-slave memory bus arbiter: fixed priority m2 > m0 > m1 with a
// starvation guard for m1, and a one-cycle ACCESS followed by a one-cycle RESP per transaction.
module mem_bus_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_rvalid_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_rvalid_o,
  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_data_i,
  output logic [DATA_W-1:0] m2_data_o,
  output logic              m2_rvalid_o,
  output logic [ADDR_W-1:0] s0_addr_o,
  output logic [DATA_W-1:0] s0_data_o,
  output logic              s0_we_o,
  input  logic [DATA_W-1:0] s0_data_i,
  output logic [ADDR_W-1:0] s1_addr_o,
  output logic [DATA_W-1:0] s1_data_o,
  output logic              s1_we_o,
  input  logic [DATA_W-1:0] s1_data_i,
  output logic [ADDR_W-1:0] s2_addr_o,
  output logic [DATA_W-1:0] s2_data_o,
  output logic              s2_we_o,
  input  logic [DATA_W-1:0] s2_data_i,
  output logic              hold_flag_o,
  output logic              dec_err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [1:0] NONE       = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [2:0]             req;
  logic [2:0]             m_we;
  logic [2:0][ADDR_W-1:0] m_addr;
  logic [2:0][DATA_W-1:0] m_wdata;
  logic [2:0][DATA_W-1:0] s_rdata;

  assign req     = {m2_req_i, m1_req_i, m0_req_i};
  assign m_we    = {m2_we_i, m1_we_i, m0_we_i};
  assign m_addr  = {m2_addr_i, m1_addr_i, m0_addr_i};
  assign m_wdata = {m2_data_i, m1_data_i, m0_data_i};
  assign s_rdata = {s2_data_i, s1_data_i, s0_data_i};

  state_t                 state_q;
  logic [1:0]             owner_q;
  logic [1:0]             sel_q;
  logic                   we_q;
  logic [3:0]             starve_q;
  logic [2:0][ADDR_W-1:0] s_addr_q;
  logic [2:0][DATA_W-1:0] s_data_q;
  logic [2:0]             s_we_q;
  logic [2:0][DATA_W-1:0] m_rdata_q;
  logic [2:0]             m_rvalid_q;
  logic                   dec_err_q;

  logic [1:0]             winner;
  logic                   win_we;
  logic [ADDR_W-1:0]      win_addr;
  logic [DATA_W-1:0]      win_data;
  logic [1:0]             win_sel;
  logic [2:0]             win_hit;
  logic [DATA_W-1:0]      resp_data;

  function automatic logic [1:0] decode(input logic [ADDR_W-1:0] a);
    case (a[ADDR_W-1 -: 4])
      4'h0:    decode = 2'd0;
      4'h1:    decode = 2'd1;
      4'h2:    decode = 2'd2;
      default: decode = NONE;
    endcase
  endfunction

  // A starved fetch overrides the fixed order for exactly one grant.
  always_comb begin
    winner = NONE;
    if (req[1] && (starve_q == STARVE_LIM)) winner = 2'd1;
    else if (req[2])                         winner = 2'd2;
    else if (req[0])                         winner = 2'd0;
    else if (req[1])                         winner = 2'd1;
  end

  always_comb begin
    win_we   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int n = 0; n < 3; n++) begin
      if (winner == 2'(n)) begin
        win_we   = m_we[n];
        win_addr = m_addr[n];
        win_data = m_wdata[n];
      end
    end
  end

  assign win_sel = decode(win_addr);

  for (genvar gi = 0; gi < 3; gi++) begin : g_hit
    assign win_hit[gi] = (win_sel == 2'(gi));
  end

  // Writes and undecoded addresses both answer with zero.
  always_comb begin
    resp_data = '0;
    if (!we_q) begin
      for (int k = 0; k < 3; k++) begin
        if (sel_q == 2'(k)) resp_data = s_rdata[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_q    <= NONE;
      sel_q      <= NONE;
      we_q       <= 1'b0;
      starve_q   <= '0;
      s_addr_q   <= '0;
      s_data_q   <= '0;
      s_we_q     <= '0;
      m_rdata_q  <= '0;
      m_rvalid_q <= '0;
      dec_err_q  <= 1'b0;
    end else begin
      m_rvalid_q <= '0;
      dec_err_q  <= 1'b0;
      case (state_q)
        ACCESS: begin
          s_addr_q <= '0;
          s_data_q <= '0;
          s_we_q   <= '0;
          for (int n = 0; n < 3; n++) begin
            if (owner_q == 2'(n)) begin
              m_rvalid_q[n] <= 1'b1;
              m_rdata_q[n]  <= resp_data;
            end
          end
          dec_err_q <= (sel_q == NONE);
          state_q   <= RESP;
        end
        default: begin
          if (req[1] && (winner != 2'd1))
            starve_q <= (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
          else
            starve_q <= '0;
          if (winner != NONE) begin
            state_q <= ACCESS;
            owner_q <= winner;
            we_q    <= win_we;
            sel_q   <= win_sel;
            for (int k = 0; k < 3; k++) begin
              s_we_q[k]   <= win_hit[k] & win_we;
              s_addr_q[k] <= win_hit[k] ? win_addr : '0;
              s_data_q[k] <= win_hit[k] ? win_data : '0;
            end
          end else begin
            state_q <= IDLE;
            owner_q <= NONE;
          end
        end
      endcase
    end
  end

  assign hold_flag_o = m2_req_i | ((state_q != IDLE) && (owner_q == 2'd2));
  assign dec_err_o   = dec_err_q;

  assign m0_data_o   = m_rdata_q[0];
  assign m1_data_o   = m_rdata_q[1];
  assign m2_data_o   = m_rdata_q[2];
  assign m0_rvalid_o = m_rvalid_q[0];
  assign m1_rvalid_o = m_rvalid_q[1];
  assign m2_rvalid_o = m_rvalid_q[2];

  assign s0_addr_o   = s_addr_q[0];
  assign s1_addr_o   = s_addr_q[1];
  assign s2_addr_o   = s_addr_q[2];
  assign s0_data_o   = s_data_q[0];
  assign s1_data_o   = s_data_q[1];
  assign s2_data_o   = s_data_q[2];
  assign s0_we_o     = s_we_q[0];
  assign s1_we_o     = s_we_q[1];
  assign s2_we_o     = s_we_q[2];

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the SoC memory bus between three masters: m0 (core load/store), m1 (core instruction fetch) and m2 (JTAG debug memory port). It decodes each address onto three slaves: s0 ROM, s1 RAM and s2 peripheral. The block arbitrates with fixed priority plus a starvation guard for fetch, runs each transaction as a two-phase access/response sequence, and stalls the core pipeline while the debugger owns the bus. It sits between core/jtag_top and rom/ram in soc_top.

Parameters:
ADDR_W, 32, address width for all masters and slaves
DATA_W, 32, data width
STARVE_MAX, 8, consecutive denied cycles of m1 before m1 is forced to the top priority (range 1..15)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
mN_req_i  in  1  request from master N, N=0..2; held until the master sees rvalid
mN_we_i  in  1  write enable from master N
mN_addr_i  in  ADDR_W  address from master N
mN_data_i  in  DATA_W  write data from master N
mN_data_o  out  DATA_W  read data to master N
mN_rvalid_o  out  1  one-cycle completion pulse to master N
sK_addr_o  out  ADDR_W  address to slave K, K=0..2
sK_data_o  out  DATA_W  write data to slave K
sK_we_o  out  1  write strobe to slave K
sK_data_i  in  DATA_W  read data from slave K (combinational read)
hold_flag_o  out  1  stall request to the core pipeline
dec_err_o  out  1  one-cycle pulse: an address did not decode to any slave

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All state and registered outputs are cleared asynchronously on rst.
- Reset values: state=IDLE, owner=none, starve_cnt=0. All mN_data_o=0, mN_rvalid_o=0, sK_we_o=0, sK_addr_o=0, sK_data_o=0, dec_err_o=0.
- Arbitration is evaluated in IDLE and in RESP.
  - Default priority: m2 > m0 > m1.
  - If starve_cnt==STARVE_MAX and m1_req_i=1, m1 wins regardless of the others.
  - The winner is latched as owner, together with its we, addr and data. The FSM then goes to ACCESS.
  - With no request, IDLE stays in IDLE, and RESP goes to IDLE.
- ACCESS (exactly 1 cycle): the latched address is decoded on addr[31:28].
  - 0x0 selects s0, 0x1 selects s1, 0x2 selects s2.
  - The selected slave gets addr, data and we=latched we. Non-selected slaves get we=0 and addr=0.
  - Read data from the selected sK_data_i is captured into a response register. The FSM then goes to RESP.
  - Any other region: no slave strobe, response data=0, dec_err_o pulses in the RESP cycle.
- RESP (exactly 1 cycle): owner's mN_rvalid_o=1 and mN_data_o=response data (writes return 0). The other masters' rvalid stays 0. Their data_o holds its last value.
- Latency: the grant cycle is followed by ACCESS at +1 and rvalid at +2. Back-to-back throughput is one transaction per 2 cycles.
- A master must deassert req, or present a new request, on the cycle after rvalid. A req still high during RESP is treated as a new request.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each arbitration point where m1_req_i=1 and m1 is not granted.
  - Clears when m1 is granted, or when m1_req_i=0 at an arbitration point.
- hold_flag_o is combinational. It is 1 when m2_req_i=1, or when state≠IDLE and owner==m2; otherwise 0.
- Simultaneous events:
  - All three masters request in IDLE: m2 is granted first, then m0, with m1 last unless starved.
  - A master request changing during ACCESS or RESP does not affect the in-flight transaction; its signals are latched at grant.
- Reset mid-transaction: the FSM returns to IDLE immediately, no rvalid is issued, and in-flight writes are dropped. sK_we_o drops asynchronously.

Test Plan:
- Single read: m0 reads 0x1000_0004 with RAM word=0xDEADBEEF. s1_addr_o=0x1000_0004 with we=0 in ACCESS, then m0_rvalid_o=1 and m0_data_o=0xDEADBEEF two cycles after req.
- Write: m2 writes 0x0000_0010 with data 0x12345678. s0_we_o=1 for exactly one cycle, m2_rvalid_o pulses, and hold_flag_o=1 from the req cycle through RESP.
- Priority: m0, m1 and m2 all request continuously from IDLE. Grant order is m2, m2 while it stays requesting, and so on. After m2 drops, grant order is m0 then m1.
- Starvation: m0 requests continuously while m1 also requests. m1 is granted at the 9th arbitration point (STARVE_MAX=8), and starve_cnt returns to 0.
- Decode error: m0 reads 0x5000_0000. No sK_we_o, dec_err_o=1 in the RESP cycle, m0_data_o=0 and m0_rvalid_o=1.
- Reset in ACCESS: assert rst while a write is in ACCESS. sK_we_o drops to 0 without waiting for clk, no rvalid is issued, and the FSM is in IDLE after rst is released.
